usb_rx_packet_writer: RTL and testbench

- Receive-side packet stage that sits directly upstream of the top-level USB packet buffer.
- Consumes the decoded byte stream from the USB receive front end (after NRZI decode, bit unstuffing and SYNC/EOP detection).
- Validates PID and CRC16, packs payload bytes little-endian into 32-bit words and writes them into the packet buffer.
- Raises got_usb_packet with the payload length so the buffer is handed to the core.

---
 rtl/usb_rx_packet_writer.sv | 180 ++++++++++++++++++
 tb/tb_usb_rx_packet_writer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_packet_writer.sv
// Purpose : validate an incoming USB DATA0/DATA1 packet, pack its bytes little-endian into 32-bit words, write them to the packet buffer.
// Latency : a word is written 1 cycle after its 4th byte; got_usb_packet follows the end of packet by 2-3 cycles.
// Backpressure: none on the byte stream; while usb_packet_ready=1 (core owns buffer) whole packets are dropped.
//
// Ports:
//   clk48, reset_n                      clock and asynchronous active-low reset
//   rx_packet_start / rx_packet_end     SYNC / EOP pulses from the receive front end
//   rx_byte, rx_byte_valid, rx_error    decoded byte stream and abort indication
//   usb_packet_ready                    core currently owns the packet buffer
//   usb_packet_buffer_*                 word write port into the packet buffer
//   got_usb_packet, usb_data_length     accepted-packet pulse and payload length (held until next accept)
//
// Optional feature macro: USB_RX_CRC_CHECK_EN -- when defined, the CRC16 residual gates acceptance;
// when undefined no CRC logic is built and any packet with at least 2 bytes after the PID is accepted.
module usb_rx_packet_writer #(
    parameter int BUFFER_BYTES = 1024,
    parameter int LENGTH_WIDTH = 10
) (
    input  logic                                  clk48,
    input  logic                                  reset_n,
    input  logic                                  rx_packet_start,
    input  logic [7:0]                            rx_byte,
    input  logic                                  rx_byte_valid,
    input  logic                                  rx_packet_end,
    input  logic                                  rx_error,
    input  logic                                  usb_packet_ready,
    output logic [$clog2(BUFFER_BYTES/4)-1:0]     usb_packet_buffer_address,
    output logic [31:0]                           usb_packet_buffer_write_value,
    output logic                                  write_to_usb_packet_buffer,
    output logic                                  got_usb_packet,
    output logic [LENGTH_WIDTH-1:0]               usb_data_length
);

    localparam int ADDR_W = $clog2(BUFFER_BYTES/4);
    // One extra bit so the count can reach BUFFER_BYTES exactly.
    localparam int CNT_W  = $clog2(BUFFER_BYTES) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUFFER_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IGNORE,
        S_PID,
        S_DATA,
        S_FLUSH,
        S_CHECK
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] byte_cnt;
    // Lanes 0..2 of the word being built; lane 3 goes straight into the write value.
    logic [23:0]      acc;
    logic             pid_ok;
    logic             crc_ok;
    logic             byte_take;
    logic             flush_take;
    logic             accept;

    // PID check nibble must be the complement of the type nibble; only DATA0/DATA1 carry payload.
    assign pid_ok = (rx_byte[7:4] == ~rx_byte[3:0]) &&
                    ((rx_byte[3:0] == 4'b0011) || (rx_byte[3:0] == 4'b1011));

`ifdef USB_RX_CRC_CHECK_EN
    logic [15:0] crc;

    // Reflected CRC16 (poly 0xA001), one byte LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Running over data plus its transmitted (inverted) CRC leaves this fixed residual.
    assign crc_ok = (crc == 16'hB001);
`else
    assign crc_ok = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        if (rx_packet_start) begin
            state_nxt = usb_packet_ready ? S_IGNORE : S_PID;
        end else begin
            case (state)
                S_IDLE:   state_nxt = S_IDLE;
                S_IGNORE: if (rx_packet_end || rx_error) state_nxt = S_IDLE;
                S_PID: begin
                    if (rx_error || rx_packet_end) state_nxt = S_IDLE;
                    else if (rx_byte_valid)        state_nxt = pid_ok ? S_DATA : S_IGNORE;
                end
                S_DATA: begin
                    if (rx_error)                                     state_nxt = S_IDLE;
                    else if (rx_byte_valid && byte_cnt == FULL_COUNT) state_nxt = S_IGNORE;
                    else if (rx_packet_end)
                        state_nxt = (byte_cnt[1:0] != 2'd0) ? S_FLUSH : S_CHECK;
                end
                S_FLUSH:  state_nxt = rx_error ? S_IDLE : S_CHECK;
                S_CHECK:  state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath actions only fire on the transitions that keep the packet alive,
    // so a restart or abort in the same cycle suppresses them.
    assign byte_take  = (state == S_DATA) && (state_nxt == S_DATA) && rx_byte_valid;
    assign flush_take = (state == S_FLUSH) && (state_nxt == S_CHECK);
    assign accept     = (state == S_CHECK) && (state_nxt == S_IDLE) &&
                        (byte_cnt >= CNT_W'(2)) && crc_ok;

    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt                      <= '0;
            acc                           <= '0;
            usb_packet_buffer_address     <= '0;
            usb_packet_buffer_write_value <= '0;
            write_to_usb_packet_buffer    <= 1'b0;
            got_usb_packet                <= 1'b0;
            usb_data_length               <= '0;
`ifdef USB_RX_CRC_CHECK_EN
            crc                           <= '0;
`endif
        end else begin
            write_to_usb_packet_buffer <= 1'b0;
            got_usb_packet             <= 1'b0;

            if ((state == S_PID) && (state_nxt == S_DATA)) begin
                byte_cnt <= '0;
                acc      <= '0;
`ifdef USB_RX_CRC_CHECK_EN
                crc      <= 16'hFFFF;
`endif
            end

            if (byte_take) begin
                case (byte_cnt[1:0])
                    2'd0: acc[7:0]   <= rx_byte;
                    2'd1: acc[15:8]  <= rx_byte;
                    2'd2: acc[23:16] <= rx_byte;
                    default: begin
                        write_to_usb_packet_buffer    <= 1'b1;
                        usb_packet_buffer_address     <= byte_cnt[ADDR_W+1:2];
                        usb_packet_buffer_write_value <= {rx_byte, acc};
                        acc                           <= '0;
                    end
                endcase
                byte_cnt <= byte_cnt + CNT_W'(1);
`ifdef USB_RX_CRC_CHECK_EN
                crc      <= crc16_byte(crc, rx_byte);
`endif
            end

            // Unfilled lanes are already zero because the accumulator is cleared per word.
            if (flush_take) begin
                write_to_usb_packet_buffer    <= 1'b1;
                usb_packet_buffer_address     <= byte_cnt[ADDR_W+1:2];
                usb_packet_buffer_write_value <= {8'h00, acc};
                acc                           <= '0;
            end

            // The two CRC bytes are stored but not reported in the length.
            if (accept) begin
                got_usb_packet  <= 1'b1;
                usb_data_length <= LENGTH_WIDTH'(byte_cnt - CNT_W'(2));
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_packet_writer.sv
// Purpose : self-checking bench for usb_rx_packet_writer; expected writes/pulses queued, monitor compares.
// Latency : full-word writes are checked to land exactly 1 cycle after their last byte.
// Backpressure: ownership (usb_packet_ready) drop behaviour is exercised directly.
module tb_usb_rx_packet_writer;

    logic        clk48 = 1'b0;
    logic        reset_n = 1'b1;
    logic        rx_packet_start = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_byte_valid = 1'b0;
    logic        rx_packet_end = 1'b0;
    logic        rx_error = 1'b0;
    logic        usb_packet_ready = 1'b0;
    logic [7:0]  usb_packet_buffer_address;
    logic [31:0] usb_packet_buffer_write_value;
    logic        write_to_usb_packet_buffer;
    logic        got_usb_packet;
    logic [9:0]  usb_data_length;

    usb_rx_packet_writer #(.BUFFER_BYTES(1024), .LENGTH_WIDTH(10)) dut (
        .clk48                         (clk48),
        .reset_n                       (reset_n),
        .rx_packet_start               (rx_packet_start),
        .rx_byte                       (rx_byte),
        .rx_byte_valid                 (rx_byte_valid),
        .rx_packet_end                 (rx_packet_end),
        .rx_error                      (rx_error),
        .usb_packet_ready              (usb_packet_ready),
        .usb_packet_buffer_address     (usb_packet_buffer_address),
        .usb_packet_buffer_write_value (usb_packet_buffer_write_value),
        .write_to_usb_packet_buffer    (write_to_usb_packet_buffer),
        .got_usb_packet                (got_usb_packet),
        .usb_data_length               (usb_data_length)
    );

    always #5 clk48 = ~clk48;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] v;
        bit          lat;
    } wexp_t;

    wexp_t      wq[$];
    logic [9:0] gq[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_byte_cyc = -100;

    always @(posedge clk48) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT write / pulse against the scoreboard queues.
    always @(negedge clk48) begin
        wexp_t e;
        if (rx_byte_valid) last_byte_cyc = cyc;
        if (reset_n) begin
            if (write_to_usb_packet_buffer || got_usb_packet)
                chk("write_and_pulse_overlap", 32'(write_to_usb_packet_buffer & got_usb_packet), 32'd0);
            if (write_to_usb_packet_buffer) begin
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: actual addr %h value %h, required no write",
                             usb_packet_buffer_address, usb_packet_buffer_write_value);
                end else begin
                    e = wq.pop_front();
                    chk("write_addr", 32'(usb_packet_buffer_address), 32'(e.a));
                    chk("write_value", usb_packet_buffer_write_value, e.v);
                    if (e.lat) chk("write_latency", 32'(cyc - last_byte_cyc), 32'd1);
                end
            end
            if (got_usb_packet) begin
                if (gq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pulse: actual length %0d, required no pulse", usb_data_length);
                end else begin
                    chk("data_length", 32'(usb_data_length), 32'(gq.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk48);
        #1;
    endtask

    task automatic pulse_start();
        rx_packet_start = 1'b1; tick();
        rx_packet_start = 1'b0; tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b; rx_byte_valid = 1'b1; tick();
        rx_byte_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_end();
        rx_packet_end = 1'b1; tick();
        rx_packet_end = 1'b0; tick();
    endtask

    task automatic send_pkt(input logic [7:0] pid, input logic [7:0] pl[$]);
        pulse_start();
        send_byte(pid);
        foreach (pl[i]) send_byte(pl[i]);
        pulse_end();
    endtask

    // Little-endian word packing of everything after the PID (CRC bytes included).
    task automatic expect_writes(input logic [7:0] pl[$]);
        logic [31:0] w;
        wexp_t e;
        int n;
        w = '0;
        n = pl.size();
        for (int i = 0; i < n; i++) begin
            w[8*(i%4) +: 8] = pl[i];
            if (i % 4 == 3) begin
                e.a = 8'(i / 4); e.v = w; e.lat = 1'b1;
                wq.push_back(e);
                w = '0;
            end
        end
        if (n % 4 != 0) begin
            e.a = 8'(n / 4); e.v = w; e.lat = 1'b0;
            wq.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        repeat (12) tick();
        chk({name, "_writes_outstanding"}, 32'(wq.size()), 32'd0);
        chk({name, "_pulses_outstanding"}, 32'(gq.size()), 32'd0);
        wq.delete();
        gq.delete();
    endtask

    // Reference CRC16-USB: data xored into the register, then 8 right shifts.
    function automatic logic [15:0] crc_model(input logic [7:0] d[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (d[k]) begin
            c = c ^ {8'h00, d[k]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    task automatic check_outputs_zero(input string name);
        chk({name, "_write"},   32'(write_to_usb_packet_buffer), 32'd0);
        chk({name, "_pulse"},   32'(got_usb_packet), 32'd0);
        chk({name, "_addr"},    32'(usb_packet_buffer_address), 32'd0);
        chk({name, "_value"},   usb_packet_buffer_write_value, 32'd0);
        chk({name, "_length"},  32'(usb_data_length), 32'd0);
    endtask

    initial begin
        logic [7:0]  zpl[$];
        logic [7:0]  pl4[$];
        logic [7:0]  badpl[$];
        logic [7:0]  abort_pl[$];
        logic [7:0]  big[$];
        logic [7:0]  big_stored[$];
        logic [15:0] crc_tx;

        #2 reset_n = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Zero-length DATA0: payload is only the CRC 00 00.
        zpl = '{8'h00, 8'h00};
        expect_writes(zpl); gq.push_back(10'd0);
        send_pkt(8'hC3, zpl);
        drain("zero_len");

        // DATA1 with 4-byte payload and a correct CRC.
        pl4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        crc_tx = ~crc_model(pl4);
        pl4.push_back(crc_tx[7:0]);
        pl4.push_back(crc_tx[15:8]);
        expect_writes(pl4); gq.push_back(10'd4);
        send_pkt(8'h4B, pl4);
        drain("data1_4");

        // Corrupted last CRC byte.
        badpl = pl4;
        badpl[5] = badpl[5] ^ 8'h01;
        expect_writes(badpl);
`ifndef USB_RX_CRC_CHECK_EN
        gq.push_back(10'd4);
`endif
        send_pkt(8'h4B, badpl);
        drain("bad_crc");

        // Core owns the buffer: packet dropped entirely; then resend once released.
        usb_packet_ready = 1'b1;
        send_pkt(8'hC3, zpl);
        drain("owned");
        usb_packet_ready = 1'b0;
        expect_writes(zpl); gq.push_back(10'd0);
        send_pkt(8'hC3, zpl);
        drain("released");

        // Malformed PID.
        send_pkt(8'hC4, zpl);
        drain("bad_pid");

        // Abort after 6 bytes: only the first full word lands; trailing byte/end are ignored in IDLE.
        abort_pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        expect_writes(abort_pl);
        pulse_start();
        send_byte(8'hC3);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        rx_error = 1'b1; tick(); rx_error = 1'b0; tick();
        send_byte(8'h77);
        pulse_end();
        drain("abort");

        // Overflow: 1025 bytes, 1024 stored as 256 words, last byte drops the packet.
        for (int i = 0; i < 1025; i++) big.push_back(8'(i));
        for (int i = 0; i < 1024; i++) big_stored.push_back(8'(i));
        expect_writes(big_stored);
        send_pkt(8'hC3, big);
        drain("overflow");

        // Good packet so the length register holds a nonzero value, then reset mid-packet.
        expect_writes(pl4); gq.push_back(10'd4);
        send_pkt(8'h4B, pl4);
        drain("pre_reset");
        pulse_start();
        send_byte(8'h4B);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("mid_reset");
        tick();
        reset_n = 1'b1;
        tick();
        expect_writes(pl4); gq.push_back(10'd4);
        send_pkt(8'h4B, pl4);
        drain("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
